// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: frame-buffered pixel transmitter. Pixels are written into an
// internal buffer while idle, then streamed row by row with horizontal blanking
// between rows, framed by stream_en and closed with a one-cycle done pulse.
// H_BLANK must be at least 1.
module pixel_stream_tx #(
  parameter int unsigned BIT_DEPTH = 16,
  parameter int unsigned IMG_W     = 32,
  parameter int unsigned IMG_H     = 32,
  parameter int unsigned H_BLANK   = 4,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BIT_DEPTH-1:0] wr_data,
  input  logic                 start,
  input  logic                 abort,
  output logic                 stream_en,
  output logic                 de,
  output logic [BIT_DEPTH-1:0] out,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_drop
);

  localparam int unsigned DEPTH   = IMG_W * IMG_H;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_MAX = (IMG_W > H_BLANK) ? IMG_W : H_BLANK;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ROW_W   = $clog2(IMG_H + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    ROW,
    BLANK,
    DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ROW_W-1:0]     row;
  logic [ADDR_W-1:0]    rd_addr;
  logic [1:0]           rst_sync;
  logic                 rst_n;
  logic                 wr_ok_c;
  logic                 wr_in_range_c;
  logic [BIT_DEPTH-1:0] mem [DEPTH];

  // Reset asserts asynchronously and releases on a clean clock edge
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Writes land only while the transmitter is idle and the address is in range
  assign wr_in_range_c = (32'(wr_addr) < DEPTH);
  assign wr_ok_c       = wr_en & ~busy & wr_in_range_c;

  // Frame buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[IDX_W'(wr_addr)] <= wr_data;
    end
  end

  // Frame sequencer: outputs are registered alongside the state they belong to,
  // and rd_addr always holds the next pixel so the read lands with de
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      row       <= '0;
      rd_addr   <= '0;
      stream_en <= 1'b0;
      de        <= 1'b0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_drop <= wr_en & busy;
      if (abort) begin
        state     <= IDLE;
        cnt       <= '0;
        row       <= '0;
        rd_addr   <= '0;
        stream_en <= 1'b0;
        de        <= 1'b0;
        out       <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= LEAD;
              cnt       <= '0;
              row       <= '0;
              rd_addr   <= '0;
              stream_en <= 1'b1;
              busy      <= 1'b1;
            end
          end
          LEAD, BLANK: begin
            if (cnt == CNT_W'(H_BLANK - 1)) begin
              state   <= ROW;
              cnt     <= '0;
              de      <= 1'b1;
              out     <= mem[IDX_W'(rd_addr)];
              rd_addr <= rd_addr + ADDR_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ROW: begin
            if (cnt == CNT_W'(IMG_W - 1)) begin
              cnt <= '0;
              de  <= 1'b0;
              out <= '0;
              if (row == ROW_W'(IMG_H - 1)) begin
                state <= DONE;
                row   <= '0;
                done  <= 1'b1;
              end else begin
                state <= BLANK;
                row   <= row + ROW_W'(1);
              end
            end else begin
              cnt     <= cnt + CNT_W'(1);
              out     <= mem[IDX_W'(rd_addr)];
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end
          DONE: begin
            state     <= IDLE;
            rd_addr   <= '0;
            stream_en <= 1'b0;
            busy      <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            stream_en <= 1'b0;
            busy      <= 1'b0;
            de        <= 1'b0;
            out       <= '0;
          end
        endcase
      end
    end
  end

endmodule
